// File: rtl/snn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snn_pkg
// Description : Shared types and constants for the SNN step scheduler:
//               scheduler state encoding, drop-counter width, timer width
//               and an index-width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package snn_pkg;

    // Scheduler states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EVENT  = 2'd1,
        UPDATE = 2'd2
    } sched_state_e;

    // Width of the saturating dropped-pulse counter
    localparam int DROP_CNT_W = 8;

    // Width of the timestep prescaler
    localparam int TIMER_W = 24;

    // Bits needed to index n items; never less than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/snn_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : snn_rr_arbiter
// Description : Combinational round-robin picker. Returns the first pending
//               channel at or after rr_ptr (wrapping) and whether any
//               channel is pending.
// Revision    : 1.0 - initial release
// ============================================================================
module snn_rr_arbiter
    import snn_pkg::*;
#(
    parameter int NUM_IN = 3
) (
    input  logic [NUM_IN-1:0]             pending,
    input  logic [idx_width(NUM_IN)-1:0]  rr_ptr,
    output logic [idx_width(NUM_IN)-1:0]  grant,
    output logic                          any
);

    localparam int c_src_w = idx_width(NUM_IN);

    logic [c_src_w-1:0] w_idx;

    // Scan from the farthest rotation back to rr_ptr so the nearest hit wins
    always_comb begin
        grant = '0;
        any   = 1'b0;
        w_idx = '0;
        for (int k = NUM_IN - 1; k >= 0; k--) begin
            w_idx = c_src_w'((int'(rr_ptr) + k) % NUM_IN);
            if (pending[w_idx]) begin
                grant = w_idx;
                any   = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/snn_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : snn_step_scheduler
// Description : Sequences the SNN core. Latches input spike events and
//               grants them round-robin to the synapse accumulator; a
//               prescaled timer starts each timestep, during which every
//               neuron index is walked through the neuron update unit.
//               Optional feature macro: SNN_DROP_CNT_EN adds the drop_cnt
//               output (saturating count of pulses lost to a set pending flag).
// Revision    : 1.0 - initial release
// ============================================================================
module snn_step_scheduler
    import snn_pkg::*;
#(
    parameter int                 NUM_IN      = 3,
    parameter int                 NUM_NEURONS = 3,
    parameter logic [TIMER_W-1:0] TICK_COUNT  = 24'd10000000
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ena,
    input  logic [NUM_IN-1:0]                 spike_in,
    output logic                              ev_valid,
    output logic [idx_width(NUM_IN)-1:0]      ev_src,
    input  logic                              ev_ready,
    output logic                              upd_valid,
    output logic [idx_width(NUM_NEURONS)-1:0] upd_idx,
    input  logic                              upd_ready,
    output logic                              tick,
    output logic                              busy,
    output logic                              overrun
`ifdef SNN_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]             drop_cnt
`endif
);

    localparam int                 c_src_w      = idx_width(NUM_IN);
    localparam int                 c_idx_w      = idx_width(NUM_NEURONS);
    localparam logic [c_src_w-1:0] c_last_src   = c_src_w'(NUM_IN - 1);
    localparam logic [c_idx_w-1:0] c_last_idx   = c_idx_w'(NUM_NEURONS - 1);
    localparam logic [TIMER_W-1:0] c_timer_last = TICK_COUNT - TIMER_W'(1);

    sched_state_e       r_state;
    sched_state_e       w_state_next;
    logic [TIMER_W-1:0] r_timer;
    logic               r_tick_pending;
    logic               r_overrun;
    logic               r_tick;
    logic [NUM_IN-1:0]  r_pending;
    logic [c_src_w-1:0] r_rr_ptr;
    logic [c_src_w-1:0] r_ev_src;
    logic [c_idx_w-1:0] r_upd_idx;
    logic [c_src_w-1:0] w_grant;
    logic               w_any;
    logic               w_term;
    logic               w_ev_hs;
    logic               w_upd_hs;
    logic               w_start_ev;
    logic               w_start_upd;
    logic [NUM_IN-1:0]  w_clear;

    snn_rr_arbiter #(
        .NUM_IN (NUM_IN)
    ) u_arb (
        .pending (r_pending),
        .rr_ptr  (r_rr_ptr),
        .grant   (w_grant),
        .any     (w_any)
    );

    assign w_term   = ena && (r_timer == c_timer_last);
    assign w_ev_hs  = (r_state == EVENT) && ev_ready;
    assign w_upd_hs = (r_state == UPDATE) && upd_ready;
    assign w_clear  = w_ev_hs ? ({{(NUM_IN-1){1'b0}}, 1'b1} << r_ev_src) : '0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_next;
    end

    // Next state; a pending timestep takes priority over event grants
    always_comb begin
        w_state_next = r_state;
        w_start_ev   = 1'b0;
        w_start_upd  = 1'b0;
        case (r_state)
            IDLE: begin
                if (ena && r_tick_pending) begin
                    w_state_next = UPDATE;
                    w_start_upd  = 1'b1;
                end else if (ena && w_any) begin
                    w_state_next = EVENT;
                    w_start_ev   = 1'b1;
                end
            end
            EVENT:   if (ev_ready) w_state_next = IDLE;
            UPDATE:  if (upd_ready && (r_upd_idx == c_last_idx)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Timer, tick bookkeeping, pending flags, grant and walk registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer        <= '0;
            r_tick_pending <= 1'b0;
            r_overrun      <= 1'b0;
            r_tick         <= 1'b0;
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_ev_src       <= '0;
            r_upd_idx      <= '0;
        end else begin
            if (ena) r_timer <= w_term ? '0 : r_timer + 1'b1;
            // A new expiry re-arms the tick even if the old one is consumed now
            if (w_term)           r_tick_pending <= 1'b1;
            else if (w_start_upd) r_tick_pending <= 1'b0;
            if (w_term && (r_tick_pending || (r_state == UPDATE))) r_overrun <= 1'b1;
            r_tick    <= w_start_upd;
            // New pulse wins over the handshake clear of the same channel
            r_pending <= (r_pending & ~w_clear) | spike_in;
            if (w_ev_hs)    r_rr_ptr <= (r_ev_src == c_last_src) ? '0 : r_ev_src + 1'b1;
            if (w_start_ev) r_ev_src <= w_grant;
            if (w_start_upd)                           r_upd_idx <= '0;
            else if (w_upd_hs && (r_upd_idx != c_last_idx)) r_upd_idx <= r_upd_idx + 1'b1;
        end
    end

    assign ev_valid  = (r_state == EVENT);
    assign ev_src    = r_ev_src;
    assign upd_valid = (r_state == UPDATE);
    assign upd_idx   = r_upd_idx;
    assign tick      = r_tick;
    assign busy      = (r_state != IDLE);
    assign overrun   = r_overrun;

`ifdef SNN_DROP_CNT_EN
    localparam int c_drop_max = (1 << DROP_CNT_W) - 1;

    logic [NUM_IN-1:0]     w_drop;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    int                    w_drop_sum;

    // A pulse is lost when its flag is set and not being cleared this cycle
    assign w_drop = spike_in & r_pending & ~w_clear;

    // Candidate count before saturation
    always_comb begin
        w_drop_sum = int'(r_drop_cnt) + $countones(w_drop);
    end

    // Saturating drop counter
    always_ff @(posedge clk) begin
        if (reset)                        r_drop_cnt <= '0;
        else if (w_drop_sum > c_drop_max) r_drop_cnt <= DROP_CNT_W'(c_drop_max);
        else                              r_drop_cnt <= DROP_CNT_W'(w_drop_sum);
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snn_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_snn_step_scheduler
// Description : Self-checking bench for snn_step_scheduler (NUM_IN=3,
//               NUM_NEURONS=3, TICK_COUNT=16): directed scenarios followed by
//               a randomized phase checked by a scoreboard monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snn_step_scheduler;

    localparam int NI = 3;
    localparam int NN = 3;
    localparam int TC = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       ena;
    logic [2:0] spike_in;
    logic       ev_valid;
    logic [1:0] ev_src;
    logic       ev_ready;
    logic       upd_valid;
    logic [1:0] upd_idx;
    logic       upd_ready;
    logic       tick;
    logic       busy;
    logic       overrun;
`ifdef SNN_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    int   exp_ev[$];
    int   exp_tick[$];
    int   got[$];
    int   mtimer = 0;
    int   exp_idx = 0;
    bit   hold = 1'b0;
    logic [1:0] hold_src = 2'd0;
    int   ev_low = 0;
    int   upd_low = 0;

    snn_step_scheduler #(
        .NUM_IN      (NI),
        .NUM_NEURONS (NN),
        .TICK_COUNT  (24'd16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ena       (ena),
        .spike_in  (spike_in),
        .ev_valid  (ev_valid),
        .ev_src    (ev_src),
        .ev_ready  (ev_ready),
        .upd_valid (upd_valid),
        .upd_idx   (upd_idx),
        .upd_ready (upd_ready),
        .tick      (tick),
        .busy      (busy),
        .overrun   (overrun)
`ifdef SNN_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic collect_ev(input int n, input int bound);
        got.delete();
        for (int i = 0; i < bound && got.size() < n; i++) begin
            if (ev_valid && ev_ready) got.push_back(int'(ev_src));
            step();
        end
    endtask

    task automatic check_got(input int i, input int exp, input string name);
        if (i < got.size()) check(name, got[i], exp);
        else                check(name, -1, exp);
    endtask

    task automatic wait_tick(input int bound, output bit found);
        found = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (tick) begin
                found = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; spike_in = '0; ena = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    // Random drive for one cycle; readies never stay low more than 2 cycles
    task automatic rand_step(input int mask);
        spike_in  = 3'(mask);
        ena       = ($urandom_range(0, 15) != 0);
        ev_ready  = (ev_low >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
        upd_ready = (upd_low >= 2) ? 1'b1 : ($urandom_range(0, 1) == 1);
        ev_low    = ev_ready ? 0 : ev_low + 1;
        upd_low   = upd_ready ? 0 : upd_low + 1;
        step();
    endtask

    // Scoreboard monitor: timestep model, grant order, walk order, handshake rules
    always @(negedge clk) begin
        if (reset) begin
            exp_tick.delete();
            exp_ev.delete();
            mtimer  = 0;
            exp_idx = 0;
            hold    = 1'b0;
        end else if (mon_en) begin
            if (ena) begin
                if (mtimer == TC - 1) begin
                    mtimer = 0;
                    exp_tick.push_back(cyc);
                end else begin
                    mtimer++;
                end
            end
            if (hold) check("ev_hold_stable", int'({ev_valid, ev_src}), int'({1'b1, hold_src}));
            hold     = ev_valid && !ev_ready;
            hold_src = ev_src;
            if (ev_valid && ev_ready) begin
                check("ev_expected_avail", int'(exp_ev.size() > 0), 1);
                if (exp_ev.size() > 0) check("ev_src_order", int'(ev_src), exp_ev.pop_front());
            end
            check("valids_exclusive", int'(ev_valid && upd_valid), 0);
            if (tick) begin
                check("tick_expected_avail", int'(exp_tick.size() > 0), 1);
                if (exp_tick.size() > 0) void'(exp_tick.pop_front());
                check("tick_starts_walk", int'({upd_valid, upd_idx}), int'({1'b1, 2'd0}));
                exp_idx = 0;
            end
            if (upd_valid && upd_ready) begin
                check("upd_idx_order", int'(upd_idx), exp_idx);
                exp_idx = (exp_idx + 1) % NN;
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        int seen;
        int t1;
        int t2;
        int ev_first;
        int upd_last;
        int n_t;
        int mrr;
        int last;

        // 1 Reset with all channels pulsing
        reset = 1'b1; ena = 1'b1; ev_ready = 1'b1; upd_ready = 1'b1; spike_in = 3'b111;
        step(); step();
        check("reset_outputs", int'({ev_valid, ev_src, upd_valid, upd_idx, tick, busy, overrun}), 0);
        reset = 1'b0; spike_in = '0;
        step(); check("no_ev_after_reset_1", int'(ev_valid), 0);
        step(); check("no_ev_after_reset_2", int'(ev_valid), 0);

        // 2 Round robin over all three channels, latency of two cycles
        spike_in = 3'b111; step(); spike_in = '0;
        check("latency_pending_cycle", int'(ev_valid), 0);
        step();
        check("latency_ev_valid", int'(ev_valid), 1);
        collect_ev(3, 20);
        check("rr_count", got.size(), 3);
        for (int i = 0; i < 3; i++) check_got(i, i, "rr_order");
        seen = 0;
        repeat (4) begin
            if (ev_valid) seen = 1;
            step();
        end
        check("pending_empty", seen, 0);
        spike_in = 3'b101; step(); spike_in = '0;
        collect_ev(1, 12);
        check_got(0, 0, "rr_ptr_wrapped");

        // 3 Backpressure on channel 1
        do_reset();
        ev_ready = 1'b0;
        spike_in = 3'b010; step(); spike_in = '0;
        for (int i = 0; i < 10 && !ev_valid; i++) step();
        for (int i = 0; i < 5; i++) begin
            check("bp_hold", int'({ev_valid, ev_src}), int'({1'b1, 2'd1}));
            step();
        end
        ev_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            if (ev_valid && ev_ready) seen++;
            step();
        end
        check("bp_single_handshake", seen, 1);

        // 4 Timestep walk, tick period, spike held off during the walk
        do_reset();
        wait_tick(40, found);
        check("tick_seen_first", int'(found), 1);
        t1 = cyc;
        check("walk_idx0", int'({upd_valid, busy, upd_idx}), int'({2'b11, 2'd0}));
        step(); check("walk_idx1", int'({upd_valid, busy, upd_idx}), int'({2'b11, 2'd1}));
        step(); check("walk_idx2", int'({upd_valid, busy, upd_idx}), int'({2'b11, 2'd2}));
        step(); check("walk_done", int'({upd_valid, busy}), 0);
        wait_tick(30, found);
        check("tick_seen_second", int'(found), 1);
        t2 = cyc;
        check("tick_period", t2 - t1, TC);
        spike_in = 3'b100; step(); spike_in = '0;
        ev_first = -1; upd_last = -1;
        repeat (12) begin
            if (upd_valid) upd_last = cyc;
            if (ev_valid && ev_first < 0) ev_first = cyc;
            step();
        end
        check("spike_granted", int'(ev_first >= 0), 1);
        check("spike_after_walk", int'(ev_first > upd_last), 1);

        // 5 Overrun while the update unit stalls
        do_reset();
        upd_ready = 1'b0;
        wait_tick(40, found);
        check("tick_seen_overrun", int'(found), 1);
        check("overrun_clear_at_tick", int'(overrun), 0);
        n_t = 0;
        repeat (20) begin
            step();
            if (tick) n_t++;
        end
        check("no_tick_while_stalled", n_t, 0);
        check("overrun_set", int'(overrun), 1);
        upd_ready = 1'b1;
        n_t = 0;
        repeat (10) begin
            step();
            if (tick) n_t++;
        end
        check("one_extra_tick", n_t, 1);
        repeat (20) step();
        check("overrun_sticky", int'(overrun), 1);

`ifdef SNN_DROP_CNT_EN
        // 6 Saturating drop counter
        do_reset();
        ev_ready = 1'b0;
        repeat (300) begin
            spike_in = 3'b001;
            step();
        end
        spike_in = '0;
        step();
        check("drop_cnt_saturated", int'(drop_cnt), 255);
        ev_ready = 1'b1;
`endif

        // Randomized phase with scoreboard checking
        mon_en = 1'b1;
        do_reset();
        mrr = 0;
        for (int b = 0; b < 80; b++) begin
            int mask;
            repeat ($urandom_range(0, 6)) rand_step(0);
            mask = $urandom_range(1, 7);
            last = 0;
            for (int k = 0; k < NI; k++) begin
                int c;
                c = (mrr + k) % NI;
                if ((mask & (1 << c)) != 0) begin
                    exp_ev.push_back(c);
                    last = c;
                end
            end
            mrr = (last + 1) % NI;
            rand_step(mask);
            for (int w = 0; w < 200 && exp_ev.size() > 0; w++) rand_step(0);
            check("burst_drained", exp_ev.size(), 0);
            exp_ev.delete();
        end
        for (int w = 0; w < 40 && exp_tick.size() > 0; w++) rand_step(0);
        check("ticks_delivered", exp_tick.size(), 0);
        check("no_overrun_random", int'(overrun), 0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
